// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side signal bundle for uart_tx_arbiter.
// master = arbiter side, slave = producers plus UART transmitter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ack;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy;
   logic [GW-1:0]             grant_id;
   logic                      active;
   logic                      err_timeout;

   modport master (
      input  req, req_data, tx_busy,
      output req_ack, tx_start, tx_data, grant_id, active, err_timeout
   );

   modport slave (
      output req, req_data, tx_busy,
      input  req_ack, tx_start, tx_data, grant_id, active, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_PRIO0_EN to give requester 0 strict priority over the rest.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16,
   parameter int GAP_CYCLES   = 0
) (
   input logic               clk,
   input logic               reset_n,
   uart_tx_arbiter_if.master bus
);
   localparam int          GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned NR      = NUM_REQ;
   localparam int          CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int          CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CW-1:0] BT_LAST  = CW'(BUSY_TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t              r_state;
   logic [GW-1:0]       r_ptr;
   logic [NUM_REQ-1:0]  r_req_ack;
   logic                r_tx_start;
   logic [DATA_W-1:0]   r_tx_data;
   logic [GW-1:0]       r_grant_id;
   logic                r_active;
   logic                r_err_timeout;
   logic [CW-1:0]       r_cnt;

   state_t              w_state;
   logic [GW-1:0]       w_ptr;
   logic [NUM_REQ-1:0]  w_req_ack;
   logic                w_tx_start;
   logic [DATA_W-1:0]   w_tx_data;
   logic [GW-1:0]       w_grant_id;
   logic                w_active;
   logic                w_err_timeout;
   logic [CW-1:0]       w_cnt;

   logic                w_found;
   logic [GW-1:0]       w_win;
   logic [GW-1:0]       w_idx;
   logic [GW-1:0]       w_win_ptr;
   logic [31:0]         w_ptr_ext;

   assign w_ptr_ext = 32'(r_ptr);

   // Winner search starts at ptr and wraps; requester 0 may pre-empt it.
   always_comb begin
      w_found   = 1'b0;
      w_win     = '0;
      w_idx     = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         w_idx = GW'((w_ptr_ext + k) % NR);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
      w_win_ptr = GW'((32'(w_win) + 32'd1) % NR);
`ifdef UART_TX_ARB_PRIO0_EN
      if (bus.req[0]) begin
         w_found   = 1'b1;
         w_win     = '0;
         w_win_ptr = r_ptr;
      end
`endif
   end

   always_comb begin
      w_state       = r_state;
      w_ptr         = r_ptr;
      w_req_ack     = '0;
      w_tx_start    = 1'b0;
      w_tx_data     = r_tx_data;
      w_grant_id    = r_grant_id;
      w_active      = r_active;
      w_err_timeout = 1'b0;
      w_cnt         = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (!bus.tx_busy && w_found) begin
               w_tx_data        = bus.req_data[32'(w_win) * DATA_W +: DATA_W];
               w_req_ack[w_win] = 1'b1;
               w_grant_id       = w_win;
               w_active         = 1'b1;
               w_ptr            = w_win_ptr;
               w_state          = S_START;
            end
         end
         S_START: begin
            w_tx_start = 1'b1;
            w_cnt      = '0;
            w_state    = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_state = S_WAIT_DONE;
            end else if (r_cnt == BT_LAST) begin
               w_err_timeout = 1'b1;
               w_active      = 1'b0;
               w_state       = S_IDLE;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (GAP_CYCLES > 0) begin
                  w_cnt   = '0;
                  w_state = S_GAP;
               end else begin
                  w_active = 1'b0;
                  w_state  = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_active = 1'b0;
               w_state  = S_IDLE;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_req_ack     <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_grant_id    <= '0;
         r_active      <= 1'b0;
         r_err_timeout <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_state;
         r_ptr         <= w_ptr;
         r_req_ack     <= w_req_ack;
         r_tx_start    <= w_tx_start;
         r_tx_data     <= w_tx_data;
         r_grant_id    <= w_grant_id;
         r_active      <= w_active;
         r_err_timeout <= w_err_timeout;
         r_cnt         <= w_cnt;
      end
   end

   assign bus.req_ack     = r_req_ack;
   assign bus.tx_start    = r_tx_start;
   assign bus.tx_data     = r_tx_data;
   assign bus.grant_id    = r_grant_id;
   assign bus.active      = r_active;
   assign bus.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a GAP_CYCLES=0 instance and a GAP_CYCLES=5 instance.
// Expected grant order follows UART_TX_ARB_PRIO0_EN when it is defined.
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) a_if ();
   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b_if ();

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(16), .GAP_CYCLES(0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(a_if)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(16), .GAP_CYCLES(5)) dut_gap (
      .clk(clk), .reset_n(reset_n), .bus(b_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_ack"},   32'(a_if.req_ack),     0);
      chk({tag, "_start"}, 32'(a_if.tx_start),    0);
      chk({tag, "_data"},  32'(a_if.tx_data),     0);
      chk({tag, "_gid"},   32'(a_if.grant_id),    0);
      chk({tag, "_act"},   32'(a_if.active),      0);
      chk({tag, "_err"},   32'(a_if.err_timeout), 0);
   endtask

   // Arbitration edge then tx_start edge; req is replaced right after the ack.
   task automatic grant_check(input int id, input int data, input logic [3:0] nreq);
      step();
      chk("grant_ack",    32'(a_if.req_ack),     1 << id);
      chk("grant_gid",    32'(a_if.grant_id),    id);
      chk("grant_act",    32'(a_if.active),      1);
      chk("grant_err",    32'(a_if.err_timeout), 0);
      chk("grant_start0", 32'(a_if.tx_start),    0);
      a_if.req = nreq;
      step();
      chk("start_pulse",  32'(a_if.tx_start),    1);
      chk("start_data",   32'(a_if.tx_data),     data);
      chk("start_ack0",   32'(a_if.req_ack),     0);
   endtask

   task automatic finish_frame(input int data);
      a_if.tx_busy = 1'b1;
      step();
      chk("busy_start0", 32'(a_if.tx_start), 0);
      step();
      step();
      chk("busy_ack0",   32'(a_if.req_ack),  0);
      chk("busy_act",    32'(a_if.active),   1);
      chk("busy_data",   32'(a_if.tx_data),  data);
      a_if.tx_busy = 1'b0;
      step();
      chk("done_act0",   32'(a_if.active),   0);
      chk("done_ack0",   32'(a_if.req_ack),  0);
   endtask

   int fair_id [5];
   int wrap_id [3];

   initial begin
`ifdef UART_TX_ARB_PRIO0_EN
      fair_id = '{0, 0, 0, 0, 0};
      wrap_id = '{0, 0, 0};
`else
      fair_id = '{1, 2, 3, 0, 1};
      wrap_id = '{3, 0, 3};
`endif
      reset_n       = 1'b0;
      a_if.req      = '0;
      a_if.req_data = '0;
      a_if.tx_busy  = 1'b0;
      b_if.req      = '0;
      b_if.req_data = '0;
      b_if.tx_busy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_a_zero("rst");
      chk("rst_b_act", 32'(b_if.active),  0);
      chk("rst_b_ack", 32'(b_if.req_ack), 0);
      reset_n = 1'b1;

      // Single request from requester 0.
      a_if.req_data = 32'h4332_21A5;
      a_if.req      = 4'b0001;
      grant_check(0, 'hA5, 4'b0000);
      finish_frame('hA5);

      // Fairness with all four requesting continuously (ptr starts at 1 here).
      a_if.req_data = 32'h4332_2110;
      a_if.req      = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         grant_check(fair_id[i], 'h10 + 'h11 * fair_id[i], (i == 4) ? 4'b0000 : 4'b1111);
         finish_frame('h10 + 'h11 * fair_id[i]);
      end

      // Move ptr to 3, then wrap between requesters 3 and 0.
      a_if.req = 4'b0100;
      grant_check(2, 'h32, 4'b0000);
      finish_frame('h32);
      a_if.req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         grant_check(wrap_id[i], 'h10 + 'h11 * wrap_id[i], (i == 2) ? 4'b0000 : 4'b1001);
         finish_frame('h10 + 'h11 * wrap_id[i]);
      end

      // tx_busy never rises: 16 waiting cycles then err_timeout, pending req=0100 follows.
      a_if.req = 4'b0010;
      grant_check(1, 'h21, 4'b0100);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("to_wait_err", 32'(a_if.err_timeout), 0);
         chk("to_wait_act", 32'(a_if.active),      1);
      end
      step();
      chk("to_err",  32'(a_if.err_timeout), 1);
      chk("to_act0", 32'(a_if.active),      0);
      chk("to_ack0", 32'(a_if.req_ack),     0);
      grant_check(2, 'h32, 4'b0000);
      finish_frame('h32);

      // Asynchronous reset while in WAIT_DONE.
      a_if.req = 4'b0010;
      grant_check(1, 'h21, 4'b0000);
      a_if.tx_busy = 1'b1;
      step();
      step();
      chk("pre_rst_act", 32'(a_if.active), 1);
      #3;
      reset_n = 1'b0;
      #1;
      chk_a_zero("mid_rst");
      a_if.tx_busy = 1'b0;
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      a_if.req = 4'b1001;
      grant_check(0, 'h10, 4'b0100);
      finish_frame('h10);
      grant_check(2, 'h32, 4'b0000);
      finish_frame('h32);

      // Inter-frame gap of 5 cycles on the second instance.
      b_if.req_data = 32'h0000_335A;
      b_if.req      = 4'b0001;
      step();
      chk("gap_ack0", 32'(b_if.req_ack), 1);
      b_if.req = 4'b0010;
      step();
      chk("gap_start", 32'(b_if.tx_start), 1);
      chk("gap_data",  32'(b_if.tx_data),  'h5A);
      b_if.tx_busy = 1'b1;
      step();
      step();
      b_if.tx_busy = 1'b0;
      step();
      chk("gap_e_act", 32'(b_if.active),  1);
      chk("gap_e_ack", 32'(b_if.req_ack), 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("gap_hold_ack", 32'(b_if.req_ack), 0);
         chk("gap_hold_act", 32'(b_if.active),  1);
      end
      step();
      chk("gap_end_ack", 32'(b_if.req_ack), 0);
      chk("gap_end_act", 32'(b_if.active),  0);
      step();
      chk("gap_next_ack", 32'(b_if.req_ack),  2);
      chk("gap_next_gid", 32'(b_if.grant_id), 1);
      b_if.req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers (e.g. command responder, debug logger, status reporter).
- Arbitrates round-robin, captures the winner's byte and issues a single-cycle start to the transmitter.
- Tracks the transmitter busy flag through the frame and enforces an optional inter-frame gap.
- Sits between the producers and the transmitter's transmit/TxData/busy interface.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- DATA_W, 8, byte width; must match the transmitter data width.
- BUSY_TIMEOUT, 16, max cycles after tx_start for tx_busy to rise before the frame is abandoned (>=2).
- GAP_CYCLES, 0, idle clk cycles inserted after tx_busy falls before the next grant (0 = none).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high with req_data stable until the matching req_ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-cycle pulse: byte from requester i captured.
- tx_start  out  1  one-cycle start pulse to the transmitter's transmit input.
- tx_data  out  DATA_W  byte to the transmitter; stable from tx_start until the frame ends.
- tx_busy  in  1  transmitter busy flag.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of current owner; valid while active=1.
- active  out  1  high from grant until the frame (and gap) completes.
- err_timeout  out  1  one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ptr=0; req_ack=0; tx_start=0; tx_data=0; grant_id=0; active=0; err_timeout=0; counters=0. Reset mid-frame abandons the frame; no ack or retry is owed.
- All outputs are registered.
- IDLE:
  - Arbitrate only when tx_busy=0 and some req=1.
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ... with wrap mod NUM_REQ.
  - Next cycle: tx_data<=winner's byte; req_ack[winner]=1 (single cycle); grant_id<=winner; active<=1; ptr<=(winner+1) mod NUM_REQ; state->START.
- START: tx_start=1 for exactly one cycle; timeout counter cleared; ->WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: ->WAIT_DONE.
  - Otherwise count; when the count reaches BUSY_TIMEOUT: err_timeout pulse, active<=0, ->IDLE. The byte is dropped and ptr is still advanced.
- WAIT_DONE: on tx_busy=0, ->GAP if GAP_CYCLES>0, else active<=0 and ->IDLE.
- GAP: count GAP_CYCLES cycles, then active<=0 and ->IDLE.
- Latency: req rising in IDLE -> req_ack and grant 1 cycle later -> tx_start 2 cycles after req.
- Minimum IDLE dwell is 1 cycle between frames: req is sampled there, so back-to-back grants are never merged.
- A requester whose req stays high after req_ack is treated as a new byte. Round-robin guarantees every active requester is served within NUM_REQ frames.
- req toggling while not in IDLE is ignored. Only the IDLE sample counts.
- NUM_REQ=1: ptr stays 0; grant_id is 1 bit, tied to 0.

Optional Feature:
- Macro UART_TX_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If req[0]=1 in IDLE it wins regardless of ptr, and ptr is left unchanged. The others are round-robin among themselves via ptr.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Single request: req=0001, req_data[7:0]=0xA5 -> req_ack=0001 one cycle later; tx_start one cycle after that with tx_data=0xA5; active falls the cycle after tx_busy falls (GAP_CYCLES=0).
- Fairness: req=1111 held constantly, bytes 0x10/0x21/0x32/0x43 -> grants in order 0,1,2,3,0,...; each req_ack exactly one cycle; never two acks per frame.
- Wrap: ptr=3, req=1001 -> requester 3 wins, then requester 0; ptr returns to 0 (ptr=1 after the second grant).
- Timeout: tx_busy held 0 after tx_start, BUSY_TIMEOUT=16 -> err_timeout pulses once; active=0; next pending request is granted normally.
- Reset mid-frame: reset_n low during WAIT_DONE -> all outputs 0 immediately. After release with tx_busy=0 and req=0100, requester 2 is granted with ptr starting from 0.
- Gap and prio: GAP_CYCLES=5 -> exactly 5 cycles between tx_busy falling and the next req_ack. With UART_TX_ARB_PRIO0_EN and req=1111, requester 0 wins every frame.
